// File: rtl/fetch_stage_if.sv
// fetch_stage_if: signal bundle between the fetch stage, the instruction SRAM
// and the decode stage.
//
// Handshake: fs_to_ds_valid=1 means fs_to_ds_bus (and fs_adef) hold an
// instruction for decode. It is consumed on a rising edge where
// fs_to_ds_valid=1 and ds_allowin=1. While ds_allowin=0, the fetch stage keeps
// the same instruction on the bus. br_taken is a one-cycle redirect pulse,
// and br_target is sampled in that cycle. The SRAM returns inst_sram_rdata
// exactly one cycle after a cycle with inst_sram_en=1.
interface fetch_stage_if;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        fs_adef;

  // Fetch-stage side.
  modport master (
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata,
    input  ds_allowin,
    input  br_taken,
    input  br_target,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output fs_adef
  );

  // Environment side (SRAM plus decode).
  modport slave (
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata,
    output ds_allowin,
    output br_taken,
    output br_target,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  fs_adef
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: LoongArch instruction-fetch stage.
// Owns the PC and issues nextpc to a synchronous instruction SRAM. It hands
// {pc, inst} to decode over valid/allowin. A one-cycle branch redirect kills
// the slot currently in the stage. If the target cannot issue that cycle, it
// is remembered as a pending redirect. An instruction returned while decode
// stalls is held in a one-entry buffer, because the SRAM output is only
// valid for one cycle.
//
// Optional feature macro: FETCH_ADEF_CHK_EN. When it is defined, a
// misaligned nextpc does not read the SRAM. That slot presents inst=0 with
// fs_adef=1.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic           clk,
  input  logic           resetn,
  fetch_stage_if.master  fs
);

  // Architectural state of the stage.
  logic [31:0] fs_pc;
  logic        fs_valid;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic        br_pend;
  logic [31:0] br_pend_pc;
  logic        cancel;

  // Combinational datapath.
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        adef_issue;
  logic        to_ds_valid;
  logic        handoff;
  logic        stall_capture;
  logic [31:0] raw_inst;
  logic [31:0] fs_inst;

  // Next fetch address: a live redirect wins, then a pending one, then sequential.
  always_comb begin
    seq_pc = fs_pc + 32'd4;
    nextpc = seq_pc;
    if (fs.br_taken) begin
      nextpc = fs.br_target;
    end else if (br_pend) begin
      nextpc = br_pend_pc;
    end
  end

  // The SRAM answers one cycle after issue, so a valid slot always has data.
  // The slot frees when it is handed off. A cancelled slot also frees once
  // decode allows. An empty slot always refills.
  always_comb begin
    fs_ready_go = buf_valid | fs_valid;
    fs_allowin  = !fs_valid | (fs_ready_go & fs.ds_allowin);
  end

`ifdef FETCH_ADEF_CHK_EN
  logic fs_adef_r;

  assign adef_issue = (nextpc[1:0] != 2'b00);

  // Remember whether the slot being filled came from a misaligned address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_adef_r <= 1'b0;
    end else if (fs_allowin) begin
      fs_adef_r <= adef_issue;
    end
  end

  // A faulting slot never read the SRAM, so it presents a zero instruction.
  always_comb begin
    raw_inst = buf_valid ? buf_inst : fs.inst_sram_rdata;
    fs_inst  = fs_adef_r ? 32'h0 : raw_inst;
  end

  assign fs.fs_adef = to_ds_valid & fs_adef_r;
`else
  assign adef_issue = 1'b0;

  // A buffered copy takes priority over the one-cycle SRAM output.
  always_comb begin
    raw_inst = buf_valid ? buf_inst : fs.inst_sram_rdata;
    fs_inst  = raw_inst;
  end

  assign fs.fs_adef = 1'b0;
`endif

  // SRAM request and decode-facing outputs. Reset forces the SRAM quiet and
  // the address to the boot PC.
  always_comb begin
    fs.inst_sram_en    = resetn & fs_allowin & !adef_issue;
    fs.inst_sram_we    = 1'b0;
    fs.inst_sram_wdata = 32'h0;
    fs.inst_sram_addr  = resetn ? nextpc : RESET_PC;
    to_ds_valid        = fs_valid & !fs.br_taken & !cancel;
    fs.fs_to_ds_valid  = to_ds_valid;
    fs.fs_to_ds_bus    = fs_valid ? {fs_pc, fs_inst} : 64'h0;
    handoff            = to_ds_valid & fs.ds_allowin;
    // Capture only a live slot whose data is still on the SRAM output.
    stall_capture      = fs_valid & !buf_valid & !fs.ds_allowin
                         & !fs.br_taken & !cancel;
  end

  // PC, slot valid and redirect bookkeeping. An issue consumes any pending
  // redirect. A redirect that cannot issue is parked, and the slot is marked
  // cancelled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_pc      <= RESET_PC - 32'd4;
      fs_valid   <= 1'b0;
      br_pend    <= 1'b0;
      br_pend_pc <= 32'h0;
      cancel     <= 1'b0;
    end else if (fs_allowin) begin
      fs_pc    <= nextpc;
      fs_valid <= 1'b1;
      br_pend  <= 1'b0;
      cancel   <= 1'b0;
    end else if (fs.br_taken) begin
      br_pend    <= 1'b1;
      br_pend_pc <= fs.br_target;
      cancel     <= 1'b1;
    end
  end

  // One-entry stall buffer. It is emptied by handoff or by any kill of the
  // slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_inst  <= 32'h0;
    end else if (fs.br_taken | cancel | handoff) begin
      buf_valid <= 1'b0;
    end else if (stall_capture) begin
      buf_valid <= 1'b1;
      buf_inst  <= fs.inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. It uses directed
// scenarios and then randomized decode back-pressure, redirects and resets.
// Results are compared cycle by cycle against a slot-level reference model
// and an in-order handoff scoreboard.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
`ifdef FETCH_ADEF_CHK_EN
  localparam bit ADEF_ON = 1'b1;
`else
  localparam bit ADEF_ON = 1'b0;
`endif

  // Clock and reset.
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fetch_stage_if fs ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .fs     (fs)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: {pc, inst} of every live fetch, in order, awaiting handoff.
  logic [63:0] exp_q[$];

  // Reference model state: one slot in the stage plus the next fetch address.
  logic        m_have;
  logic        m_dead;
  logic        m_adef;
  logic [31:0] m_pc;
  logic [31:0] m_next;

  // Instruction memory contents: a bijective scramble of the address, plus
  // one fixed word used by the stall scenario.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0008) return 32'h0280_0421;
    return {a[7:0], a[31:8]} ^ 32'h1357_2468;
  endfunction

  // Synchronous SRAM. Data is valid only in the cycle after a read. It is
  // junk otherwise.
  always @(posedge clk) begin
    if (fs.inst_sram_en) fs.inst_sram_rdata <= mem_word(fs.inst_sram_addr);
    else                 fs.inst_sram_rdata <= $urandom;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0;
    m_dead = 1'b0;
    m_adef = 1'b0;
    m_pc   = 32'h0;
    m_next = RESET_PC;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_en",    64'(fs.inst_sram_en),    64'd0);
    check("rst_valid", 64'(fs.fs_to_ds_valid),  64'd0);
    check("rst_bus",   fs.fs_to_ds_bus,         64'd0);
    check("rst_adef",  64'(fs.fs_adef),         64'd0);
    check("rst_addr",  64'(fs.inst_sram_addr),  64'(RESET_PC));
    check("rst_we",    64'(fs.inst_sram_we),    64'd0);
    check("rst_wdata", 64'(fs.inst_sram_wdata), 64'd0);
  endtask

  // Reset driver. Call it just after a rising edge. It asserts reset between
  // edges, holds it across one edge, and releases it just after the next edge.
  task automatic apply_reset();
    fs.br_taken   = 1'b0;
    fs.br_target  = 32'h0;
    fs.ds_allowin = 1'b1;
    #2 resetn = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    check_reset_outputs();
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
  endtask

  // One clock cycle. Drive the inputs, check all outputs against the model
  // mid-cycle, then advance the model over the rising edge.
  task automatic cycle(input logic a, input logic b, input logic [31:0] t);
    logic [31:0] exp_addr;
    logic        adef_hit;
    logic        moving;
    logic        exp_valid;
    logic [63:0] want;
    fs.ds_allowin = a;
    fs.br_taken   = b;
    fs.br_target  = t;
    @(negedge clk);
    exp_addr  = b ? t : m_next;
    adef_hit  = ADEF_ON && (exp_addr[1:0] != 2'b00);
    moving    = !m_have || a;
    exp_valid = m_have && !m_dead && !b;
    check("sram_en", 64'(fs.inst_sram_en), 64'(moving && !adef_hit));
    if (moving) check("sram_addr", 64'(fs.inst_sram_addr), 64'(exp_addr));
    check("ds_valid", 64'(fs.fs_to_ds_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("ds_bus", fs.fs_to_ds_bus, {m_pc, (m_adef ? 32'h0 : mem_word(m_pc))});
      check("ds_adef", 64'(fs.fs_adef), 64'(m_adef));
    end
    if (fs.fs_to_ds_valid && a) begin
      if (exp_q.size() != 0) want = exp_q.pop_front();
      else                   want = ~fs.fs_to_ds_bus;
      check("handoff", fs.fs_to_ds_bus, want);
    end
    if (b && m_have && !m_dead && exp_q.size() != 0) void'(exp_q.pop_back());
    if (moving) begin
      m_have = 1'b1;
      m_dead = 1'b0;
      m_pc   = exp_addr;
      m_adef = adef_hit;
      m_next = exp_addr + 32'd4;
      exp_q.push_back({exp_addr, (adef_hit ? 32'h0 : mem_word(exp_addr))});
    end else if (b) begin
      m_dead = 1'b1;
      m_next = t;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b1;
    fs.ds_allowin = 1'b0;
    fs.br_taken   = 1'b0;
    fs.br_target  = 32'h0;
    apply_reset();
    check("first_addr", 64'(fs.inst_sram_addr), 64'h1c00_0000);

    // Streaming after reset, then a 3-cycle stall while 1c000008 is presented.
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b1, 1'b0, 32'h0);
    // Branch with allowin while 1c000010 is presented.
    cycle(1'b1, 1'b1, 32'h1c00_0100);
    repeat (2) cycle(1'b1, 1'b0, 32'h0);
    // Branch during a stall, then release.
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h1c00_0200);
    cycle(1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    // Two redirects while stalled: the later target must win.
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h1c00_0300);
    cycle(1'b0, 1'b1, 32'h1c00_0400);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    // PC wrap from ffff_fffc to 0.
    cycle(1'b1, 1'b1, 32'hffff_fff8);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    // Asynchronous reset mid-stream.
    apply_reset();
    check("reissue_addr", 64'(fs.inst_sram_addr), 64'h1c00_0000);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    // Misaligned target: an address fault when the check is built in,
    // otherwise the address is passed through unchanged.
    cycle(1'b1, 1'b1, 32'h1c00_0102);
    repeat (2) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h1c00_0000);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    // Randomized back-pressure, redirects and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic        a;
      logic        b;
      logic [31:0] t;
      a = ($urandom_range(0, 99) < 70);
      b = ($urandom_range(0, 99) < 12);
      t = {4'h1, 6'h00, 20'($urandom), 2'b00};
      if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom);
      if ($urandom_range(0, 999) == 0) apply_reset();
      else cycle(a, b, t);
    end

    fs.br_taken = 1'b0;
    check("sb_left", 64'(exp_q.size()), 64'((m_have && !m_dead) ? 1 : 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage for the LoongArch CPU core. It owns the PC, drives the synchronous instruction SRAM, and hands {pc, inst} to the decode stage over a valid/allowin handshake. It accepts one-cycle branch redirects from decode and cancels wrong-path fetches. When decode stalls, it buffers a returned instruction so none is lost.

## Interface
- `RESET_PC`, default 32'h1c00_0000: address of the first instruction fetched after reset.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_sram_en`  out  1  read enable; an address is issued in a cycle with en=1.
- `inst_sram_we`  out  1  constant 0.
- `inst_sram_addr`  out  32  fetch address (nextpc).
- `inst_sram_wdata`  out  32  constant 0.
- `inst_sram_rdata`  in  32  read data, valid exactly one cycle after the issuing cycle.
- `ds_allowin`  in  1  decode can accept this cycle.
- `br_taken`  in  1  one-cycle redirect pulse from decode.
- `br_target`  in  32  redirect address, sampled when `br_taken`=1.
- `fs_to_ds_valid`  out  1  `fs_to_ds_bus` holds a valid instruction.
- `fs_to_ds_bus`  out  64  {pc[63:32], inst[31:0]}.
- `fs_adef`  out  1  fetch-address fault flag for the presented instruction.

## Operation
- Registers:
  - `fs_pc`: reset value `RESET_PC`-4.
  - `fs_valid`: reset 0.
  - `buf_valid`: reset 0.
  - `buf_inst`: reset 0.
  - `br_pend`: reset 0.
  - `br_pend_pc`: reset 0.
  - `cancel`: reset 0.
- `seq_pc` = `fs_pc`+4, modulo 2^32 (wraps at 32'hffff_fffc to 0).
- `nextpc` = `br_taken` ? `br_target` : `br_pend` ? `br_pend_pc` : `seq_pc`.
- `fs_ready_go` = `buf_valid` | `fs_valid`-data-returned.
  - Data has returned one cycle after issue; this is always true when `fs_valid`=1 under this SRAM contract.
- `fs_allowin` = !`fs_valid` | (`fs_ready_go` & `ds_allowin`).
- `inst_sram_en` = `fs_allowin`, and it is 0 during reset.
- On an issue edge: `fs_pc`<=`nextpc`, `fs_valid`<=1, and `br_pend` clears.
- `fs_to_ds_valid` = `fs_valid` & !`br_taken` & !`cancel`.
- `fs_to_ds_bus` inst field = `buf_valid` ? `buf_inst` : `inst_sram_rdata`.
- Stall capture: if `fs_valid` & !`buf_valid` & !`ds_allowin`, latch `inst_sram_rdata` into `buf_inst` and set `buf_valid`. `buf_valid` clears on handoff (`fs_to_ds_valid` & `ds_allowin`) or on cancel.
- Redirect:
  - `br_taken`=1 kills the current fs instruction: `fs_to_ds_valid` is forced 0 that cycle, and `buf_valid` clears.
  - If `fs_allowin`=1 in that cycle, `br_target` is issued immediately.
  - Otherwise `br_pend`<=1 and `br_pend_pc`<=`br_target`, and the target issues at the next allowin.
  - The in-flight `fs_valid` slot is dropped.
- Simultaneous `br_taken` and a pending redirect: the new `br_target` wins and overwrites `br_pend_pc`.
- An `resetn` assertion at any point immediately clears all state. The first issue is in the first cycle after deassertion, at `RESET_PC`.

## Timing
- Fetch latency: addr issued in cycle N; instruction presented to decode in cycle N+1 (`fs_to_ds_valid`=1).
- Throughput: one instruction per cycle while `ds_allowin`=1.
- Redirect penalty: `br_taken` in cycle N with `fs_allowin`=1 issues target in N, presented in N+1. The instruction presented in N is discarded.
- Stall: with `ds_allowin`=0, the presented bus is stable every cycle and no new address issues.
- Outputs during reset:
  - `inst_sram_en`=0, `fs_to_ds_valid`=0, `fs_to_ds_bus`=0, `fs_adef`=0.
  - `inst_sram_addr`=`RESET_PC`.

## Configuration
- `FETCH_ADEF_CHK_EN`
  - Defined: an issued `nextpc` with bits [1:0]≠0 does not enable the SRAM (`inst_sram_en`=0 for that issue). The slot becomes valid with inst=32'h0 and `fs_adef`=1. It remains subject to normal handshake and cancel rules.
  - Undefined: no check is made, `fs_adef` is tied 0, and the low two address bits are driven unmodified.

## Test plan
- Reset release with `ds_allowin`=1: addresses 1c000000, 1c000004, 1c000008 issue on consecutive cycles. `fs_to_ds_valid`=1 from the second cycle with matching pc/inst.
- Stall: `ds_allowin`=0 for 3 cycles while pc=1c000008 with inst 0x02800421 is presented. The bus holds pc=1c000008/inst=0x02800421 throughout, even though SRAM rdata changes. Next presented is 1c00000c.
- Branch with allowin: `br_taken`=1, `br_target`=1c000100 while 1c000010 is presented. `fs_to_ds_valid`=0 that cycle, addr=1c000100 issues, and the next presented pc is 1c000100.
- Branch during stall: `br_taken` with `br_target`=1c000200 arrives while stalled. No wrong-path instruction is handed off, and pc 1c000200 issues on the first allowin cycle.
- Async reset mid-stream: `resetn` pulsed low between edges. `fs_to_ds_valid` drops immediately, and the next issue is 1c000000.
- With `FETCH_ADEF_CHK_EN`: `br_target`=1c000102 gives `inst_sram_en`=0 for that issue, then presents pc=1c000102, inst=0, `fs_adef`=1.
